// File: rtl/riscv_v_exe_alu_ctrl.sv
// riscv_v_exe_alu_ctrl
// Issue sequencer for the vector execute ALUs. It accepts one decoded micro-op,
// splits vl*SEW bytes into DATA_WIDTH-bit chunks and issues one chunk per cycle
// to the selected unit. It tracks each unit's fixed latency and drives the chunk
// writebacks to the VRF.
// Optional build macro: RISCV_V_EXE_ALU_CTRL_PERF_EN adds saturating
// performance counters (busy cycles, stall cycles, completed micro-ops).
// DATA_WIDTH is expected to be at least 16 so that a chunk spans multiple bytes.
module riscv_v_exe_alu_ctrl #(
    parameter int  VLEN        = 256,
    parameter int  DATA_WIDTH  = 64,
    parameter int  ARITH_LAT   = 2,
    localparam int CHUNK_BYTES = DATA_WIDTH / 8,
    localparam int NCHUNK      = VLEN / DATA_WIDTH,
    localparam int CW          = (NCHUNK > 1) ? $clog2(NCHUNK) : 1,
    localparam int VLW         = $clog2(VLEN / 8 + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             in_unit,
    input  logic [VLW-1:0]         in_vl,
    input  logic [1:0]             in_sew,
    output logic                   in_err,
    output logic [3:0]             iss_valid,
    input  logic                   iss_ready,
    output logic [CW-1:0]          iss_chunk,
    output logic [CHUNK_BYTES-1:0] iss_be,
    output logic                   iss_last,
    output logic                   wb_valid,
    output logic [CW-1:0]          wb_chunk,
    output logic [CHUNK_BYTES-1:0] wb_be,
    output logic                   wb_last,
    input  logic                   flush
`ifdef RISCV_V_EXE_ALU_CTRL_PERF_EN
    ,
    output logic [31:0]            perf_busy_cycles,
    output logic [31:0]            perf_stall_cycles,
    output logic [31:0]            perf_uops
`endif
);

    localparam int NBW = VLW + 3;
    localparam int RBW = $clog2(CHUNK_BYTES);
    localparam int L   = ARITH_LAT;
    localparam logic [NBW-1:0] MAX_BYTES = NBW'(VLEN / 8);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] UNIT_ARITH = 2'd1;

    // Byte enables for a chunk: a partial final chunk keeps only its low bytes.
    function automatic logic [CHUNK_BYTES-1:0] chunk_be(input logic is_last,
                                                        input logic [RBW-1:0] rem);
        logic [CHUNK_BYTES-1:0] be;
        for (int b = 0; b < CHUNK_BYTES; b++) begin
            be[b] = (!is_last || (rem == {RBW{1'b0}})) ? 1'b1 : (RBW'(b) < rem);
        end
        return be;
    endfunction

    logic [1:0]             state_r;
    logic [1:0]             unit_r;
    logic [CW-1:0]          last_idx_r;
    logic [RBW-1:0]         rem_r;
    logic [3:0]             iss_valid_r;
    logic [CW-1:0]          iss_chunk_r;
    logic [CHUNK_BYTES-1:0] iss_be_r;
    logic                   iss_last_r;
    logic                   in_ready_r;
    logic                   in_err_r;

    logic [L-1:0]                        pipe_valid_r;
    logic [L-1:0]                        pipe_last_r;
    logic [L-1:0][CW-1:0]                pipe_chunk_r;
    logic [L-1:0][CHUNK_BYTES-1:0]       pipe_be_r;

    logic [NBW-1:0]         nbytes_s;
    logic [CW-1:0]          last_idx_s;
    logic [RBW-1:0]         rem_s;
    logic                   accept_s;
    logic                   issue_s;
    logic                   zero_s;
    logic                   early_ins_s;
    logic                   late_ins_s;
    logic [CW-1:0]          next_chunk_s;
    logic                   next_last_s;

    // Request decode: byte count, last chunk index and partial-chunk remainder.
    always_comb begin
        nbytes_s     = NBW'(in_vl) << in_sew;
        last_idx_s   = CW'((nbytes_s - NBW'(1)) >> RBW);
        rem_s        = nbytes_s[RBW-1:0];
        accept_s     = in_valid & in_ready;
        issue_s      = (iss_valid_r != 4'b0000) & iss_ready;
        zero_s       = accept_s & (nbytes_s == {NBW{1'b0}});
        early_ins_s  = issue_s & (unit_r == UNIT_ARITH);
        late_ins_s   = issue_s & (unit_r != UNIT_ARITH);
        next_chunk_s = iss_chunk_r + CW'(1);
        next_last_s  = (next_chunk_s == last_idx_r);
    end

    // Flush blocks acceptance in its own cycle; writebacks that would surface
    // in the flush cycle are killed along with those still in flight.
    assign in_ready  = in_ready_r & ~flush;
    assign in_err    = in_err_r;
    assign iss_valid = iss_valid_r;
    assign iss_chunk = iss_chunk_r;
    assign iss_be    = iss_be_r;
    assign iss_last  = iss_last_r;
    assign wb_valid  = pipe_valid_r[L-1] & ~flush;
    assign wb_chunk  = pipe_chunk_r[L-1];
    assign wb_be     = pipe_be_r[L-1];
    assign wb_last   = pipe_last_r[L-1] & ~flush;

    // Control FSM: accept/reject micro-ops, step through chunks, wait for drain.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_r     <= ST_IDLE;
            unit_r      <= 2'd0;
            last_idx_r  <= {CW{1'b0}};
            rem_r       <= {RBW{1'b0}};
            iss_valid_r <= 4'b0000;
            iss_chunk_r <= {CW{1'b0}};
            iss_be_r    <= {CHUNK_BYTES{1'b0}};
            iss_last_r  <= 1'b0;
            in_ready_r  <= 1'b0;
            in_err_r    <= 1'b0;
        end else begin
            in_err_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    in_ready_r <= 1'b1;
                    if (accept_s) begin
                        if (nbytes_s > MAX_BYTES) begin
                            in_err_r <= 1'b1;
                        end else if (nbytes_s != {NBW{1'b0}}) begin
                            state_r     <= ST_ISSUE;
                            in_ready_r  <= 1'b0;
                            unit_r      <= in_unit;
                            last_idx_r  <= last_idx_s;
                            rem_r       <= rem_s;
                            iss_valid_r <= 4'b0001 << in_unit;
                            iss_chunk_r <= {CW{1'b0}};
                            iss_last_r  <= (last_idx_s == {CW{1'b0}});
                            iss_be_r    <= chunk_be(last_idx_s == {CW{1'b0}}, rem_s);
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (issue_s) begin
                        if (iss_last_r) begin
                            state_r     <= ST_DRAIN;
                            iss_valid_r <= 4'b0000;
                            iss_chunk_r <= {CW{1'b0}};
                            iss_be_r    <= {CHUNK_BYTES{1'b0}};
                            iss_last_r  <= 1'b0;
                        end else begin
                            iss_chunk_r <= next_chunk_s;
                            iss_last_r  <= next_last_s;
                            iss_be_r    <= chunk_be(next_last_s, rem_r);
                        end
                    end else begin
                        state_r <= ST_ISSUE;
                    end
                end
                ST_DRAIN: begin
                    if (wb_valid && wb_last) begin
                        state_r    <= ST_IDLE;
                        in_ready_r <= 1'b1;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    in_ready_r <= 1'b0;
                end
            endcase
        end
    end

    // Latency shift register: arith issues enter at the head and travel all
    // ARITH_LAT stages; one-cycle units and the empty-op completion enter the
    // final stage directly.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            pipe_valid_r <= {L{1'b0}};
            pipe_last_r  <= {L{1'b0}};
            pipe_chunk_r <= {(L*CW){1'b0}};
            pipe_be_r    <= {(L*CHUNK_BYTES){1'b0}};
        end else begin
            for (int i = 0; i < L; i++) begin
                if ((i == L - 1) && (late_ins_s || zero_s)) begin
                    pipe_valid_r[i] <= late_ins_s;
                    pipe_last_r[i]  <= zero_s | iss_last_r;
                    pipe_chunk_r[i] <= zero_s ? {CW{1'b0}} : iss_chunk_r;
                    pipe_be_r[i]    <= zero_s ? {CHUNK_BYTES{1'b0}} : iss_be_r;
                end else if (i == 0) begin
                    pipe_valid_r[i] <= early_ins_s;
                    pipe_last_r[i]  <= early_ins_s & iss_last_r;
                    pipe_chunk_r[i] <= early_ins_s ? iss_chunk_r : {CW{1'b0}};
                    pipe_be_r[i]    <= early_ins_s ? iss_be_r : {CHUNK_BYTES{1'b0}};
                end else begin
                    pipe_valid_r[i] <= pipe_valid_r[(i > 0) ? i - 1 : 0];
                    pipe_last_r[i]  <= pipe_last_r[(i > 0) ? i - 1 : 0];
                    pipe_chunk_r[i] <= pipe_chunk_r[(i > 0) ? i - 1 : 0];
                    pipe_be_r[i]    <= pipe_be_r[(i > 0) ? i - 1 : 0];
                end
            end
        end
    end

`ifdef RISCV_V_EXE_ALU_CTRL_PERF_EN
    logic [31:0] perf_busy_r;
    logic [31:0] perf_stall_r;
    logic [31:0] perf_uops_r;

    assign perf_busy_cycles  = perf_busy_r;
    assign perf_stall_cycles = perf_stall_r;
    assign perf_uops         = perf_uops_r;

    // Saturating activity counters; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_busy_r  <= 32'd0;
            perf_stall_r <= 32'd0;
            perf_uops_r  <= 32'd0;
        end else begin
            if ((state_r != ST_IDLE) && (perf_busy_r != 32'hFFFF_FFFF)) begin
                perf_busy_r <= perf_busy_r + 32'd1;
            end else begin
                perf_busy_r <= perf_busy_r;
            end
            if ((iss_valid_r != 4'b0000) && !iss_ready && (perf_stall_r != 32'hFFFF_FFFF)) begin
                perf_stall_r <= perf_stall_r + 32'd1;
            end else begin
                perf_stall_r <= perf_stall_r;
            end
            if (wb_last && (perf_uops_r != 32'hFFFF_FFFF)) begin
                perf_uops_r <= perf_uops_r + 32'd1;
            end else begin
                perf_uops_r <= perf_uops_r;
            end
        end
    end
`endif

endmodule

// File: tb/tb_riscv_v_exe_alu_ctrl.sv
// Testbench for riscv_v_exe_alu_ctrl: directed cases plus randomized micro-ops
// checked against a chunk/latency reference model.
module tb_riscv_v_exe_alu_ctrl;

    localparam int VLEN       = 256;
    localparam int DATA_WIDTH = 64;
    localparam int ARITH_LAT  = 2;
    localparam int CB         = DATA_WIDTH / 8;
    localparam int NCHUNK     = VLEN / DATA_WIDTH;
    localparam int CW         = $clog2(NCHUNK);
    localparam int VLW        = $clog2(VLEN / 8 + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_unit;
    logic [VLW-1:0] in_vl;
    logic [1:0]    in_sew;
    logic          in_err;
    logic [3:0]    iss_valid;
    logic          iss_ready;
    logic [CW-1:0] iss_chunk;
    logic [CB-1:0] iss_be;
    logic          iss_last;
    logic          wb_valid;
    logic [CW-1:0] wb_chunk;
    logic [CB-1:0] wb_be;
    logic          wb_last;
    logic          flush;
`ifdef RISCV_V_EXE_ALU_CTRL_PERF_EN
    logic [31:0]   perf_busy_cycles;
    logic [31:0]   perf_stall_cycles;
    logic [31:0]   perf_uops;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    riscv_v_exe_alu_ctrl #(.VLEN(VLEN), .DATA_WIDTH(DATA_WIDTH), .ARITH_LAT(ARITH_LAT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_unit(in_unit),
        .in_vl(in_vl), .in_sew(in_sew), .in_err(in_err),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_chunk(iss_chunk),
        .iss_be(iss_be), .iss_last(iss_last),
        .wb_valid(wb_valid), .wb_chunk(wb_chunk), .wb_be(wb_be), .wb_last(wb_last),
        .flush(flush)
`ifdef RISCV_V_EXE_ALU_CTRL_PERF_EN
        , .perf_busy_cycles(perf_busy_cycles), .perf_stall_cycles(perf_stall_cycles),
        .perf_uops(perf_uops)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: bytes remaining in chunk k decide its byte enables.
    function automatic int model_be(input int nbytes, input int k);
        int bytes;
        bytes = nbytes - k * CB;
        if (bytes >= CB) return (1 << CB) - 1;
        return (1 << bytes) - 1;
    endfunction

    task automatic run_op(input int unit, input int vl, input int sew, input int stall_pct,
                          input int stall_chunk, input int stall_len, input int flush_chunk);
        int nbytes, n, k, lat, guard, stalls;
        int exp_t[$];
        int exp_c[$];
        int exp_b[$];
        int exp_l[$];
        logic ir, done, do_flush;
        nbytes = vl << sew;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 50) begin
            step();
            guard++;
        end
        chk("ready_wait", in_ready, 1);
        in_valid = 1'b1;
        in_unit = unit[1:0];
        in_vl = vl[VLW-1:0];
        in_sew = sew[1:0];
        step();
        in_valid = 1'b0;
        in_unit = 2'($urandom);
        in_vl = VLW'($urandom);
        in_sew = 2'($urandom);
        if (nbytes > VLEN / 8) begin
            chk("err_pulse", in_err, 1);
            chk("err_no_issue", iss_valid, 0);
            chk("err_ready", in_ready, 1);
            step();
            chk("err_pulse_end", in_err, 0);
            chk("err_no_issue2", iss_valid, 0);
            return;
        end
        if (nbytes == 0) begin
            chk("zero_wb_last", wb_last, 1);
            chk("zero_wb_valid", wb_valid, 0);
            chk("zero_no_issue", iss_valid, 0);
            chk("zero_ready", in_ready, 1);
            step();
            chk("zero_wb_last_end", wb_last, 0);
            return;
        end
        n = (nbytes + CB - 1) / CB;
        lat = (unit == 1) ? ARITH_LAT : 1;
        k = 0;
        stalls = 0;
        done = 1'b0;
        do_flush = 1'b0;
        guard = 0;
        while (!done && guard < 300) begin
            guard++;
            if (wb_valid) begin
                if (exp_t.size() == 0) begin
                    chk("wb_unexpected", wb_valid, 0);
                end else begin
                    chk("wb_time", cyc, exp_t[0]);
                    chk("wb_chunk", wb_chunk, exp_c[0]);
                    chk("wb_be", wb_be, exp_b[0]);
                    chk("wb_last", wb_last, exp_l[0]);
                    if (exp_l[0] != 0) done = 1'b1;
                    void'(exp_t.pop_front());
                    void'(exp_c.pop_front());
                    void'(exp_b.pop_front());
                    void'(exp_l.pop_front());
                end
            end else if (exp_t.size() > 0 && exp_t[0] <= cyc) begin
                chk("wb_missing", wb_valid, 1);
                void'(exp_t.pop_front());
                void'(exp_c.pop_front());
                void'(exp_b.pop_front());
                void'(exp_l.pop_front());
            end
            chk("busy_not_ready", in_ready, 0);
            if (k < n) begin
                chk("iss_valid", iss_valid, 32'(1 << unit));
                chk("iss_chunk", iss_chunk, k);
                chk("iss_be", iss_be, model_be(nbytes, k));
                chk("iss_last", iss_last, (k == n - 1) ? 1 : 0);
                if (k == stall_chunk && stalls < stall_len) begin
                    ir = 1'b0;
                    stalls++;
                end else begin
                    ir = ($urandom_range(99) >= stall_pct);
                end
                iss_ready = ir;
                if (ir) begin
                    exp_t.push_back(cyc + lat);
                    exp_c.push_back(k);
                    exp_b.push_back(model_be(nbytes, k));
                    exp_l.push_back((k == n - 1) ? 1 : 0);
                    if (k == flush_chunk) do_flush = 1'b1;
                    k++;
                end
            end else begin
                chk("iss_idle_drain", iss_valid, 0);
                iss_ready = 1'($urandom);
            end
            if (!done) step();
            if (do_flush) begin
                flush = 1'b1;
                iss_ready = 1'($urandom);
                #1;
                chk("flush_in_ready", in_ready, 0);
                chk("flush_wb_kill", wb_valid, 0);
                step();
                flush = 1'b0;
                chk("flush_iss_off", iss_valid, 0);
                chk("flush_wb_off", wb_valid, 0);
                chk("flush_wb_last_off", wb_last, 0);
                step();
                chk("flush_ready_back", in_ready, 1);
                chk("flush_wb_off2", wb_valid, 0);
                step();
                chk("flush_wb_off3", wb_valid, 0);
                return;
            end
        end
        chk("op_done", done, 1);
        chk("op_all_issued", k, n);
        step();
        chk("ready_after_last", in_ready, 1);
        chk("wb_queue_empty", exp_t.size(), 0);
        chk("wb_after_last", wb_valid, 0);
    endtask

    initial begin
        int u, v, s, f;
        rst = 1'b1;
        in_valid = 1'b0;
        in_unit = 2'd0;
        in_vl = '0;
        in_sew = 2'd0;
        iss_ready = 1'b1;
        flush = 1'b0;
        step();
        step();
        step();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_iss_valid", iss_valid, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_last", wb_last, 0);
        chk("rst_in_err", in_err, 0);
        rst = 1'b0;
        step();
        chk("rst_release_ready", in_ready, 1);

        // Plan cases 1-5.
        run_op(0, 32, 0, 0, -1, 0, -1);
        run_op(1, 5, 1, 0, -1, 0, -1);
        run_op(2, 0, 0, 0, -1, 0, -1);
        run_op(3, 9, 2, 0, -1, 0, -1);
        run_op(2, 32, 0, 0, 1, 3, -1);
        run_op(1, 32, 0, 0, -1, 0, 2);
        run_op(3, 4, 3, 0, -1, 0, -1);
        run_op(0, 3, 0, 0, -1, 0, -1);

        // Reset asserted mid-issue.
        iss_ready = 1'b1;
        in_valid = 1'b1;
        in_unit = 2'd1;
        in_vl = VLW'(32);
        in_sew = 2'd0;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk("midrst_iss_valid", iss_valid, 0);
        chk("midrst_iss_chunk", iss_chunk, 0);
        chk("midrst_iss_be", iss_be, 0);
        chk("midrst_iss_last", iss_last, 0);
        chk("midrst_wb_valid", wb_valid, 0);
        chk("midrst_wb_last", wb_last, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_in_err", in_err, 0);
`ifdef RISCV_V_EXE_ALU_CTRL_PERF_EN
        chk("midrst_perf_busy", perf_busy_cycles, 0);
        chk("midrst_perf_stall", perf_stall_cycles, 0);
        chk("midrst_perf_uops", perf_uops, 0);
`endif
        rst = 1'b0;
        step();
        chk("midrst_ready_back", in_ready, 1);
        chk("midrst_wb_none", wb_valid, 0);
        step();
        chk("midrst_wb_none2", wb_valid, 0);

        // Randomized micro-ops with stalls and occasional flushes.
        for (int i = 0; i < 60; i++) begin
            u = $urandom_range(3);
            v = $urandom_range(40);
            s = $urandom_range(3);
            f = ($urandom_range(99) < 20) ? $urandom_range(3) : -1;
            run_op(u, v, s, 30, -1, 0, f);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscv_v_exe_alu_ctrl.md
Name: riscv_v_exe_alu_ctrl

Overview:
Issue sequencer for the vector execute ALUs (logic, arithmetic, mask, permutation). It accepts one decoded vector micro-op at a time and splits the vector (vl elements at SEW) into DATA_WIDTH-bit chunks. It issues one chunk per cycle to the selected ALU, tracks each ALU's fixed latency and drives chunk writeback to the VRF. It sits between the vector decode/dispatch stage and the riscv_v_exe_alu datapath.

Parameters:
VLEN, 256, vector register length in bits
DATA_WIDTH, 64, ALU datapath width in bits; CHUNK_BYTES = DATA_WIDTH/8; VLEN must be a multiple of DATA_WIDTH
ARITH_LAT, 2, arithmetic ALU latency in cycles (>=1); the other ALUs are fixed at 1

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  micro-op valid
in_ready  out  1  controller can accept a micro-op
in_unit  in  2  0=logic, 1=arith, 2=mask, 3=perm
in_vl  in  $clog2(VLEN/8+1)  vector length in elements
in_sew  in  2  element width 0=8b, 1=16b, 2=32b, 3=64b
in_err  out  1  one-cycle pulse: illegal vl/sew rejected
iss_valid  out  4  one-hot per-unit issue valid
iss_ready  in  1  operand read stage ready
iss_chunk  out  $clog2(VLEN/DATA_WIDTH)  chunk index
iss_be  out  CHUNK_BYTES  byte enables for the chunk
iss_last  out  1  final chunk of the micro-op
wb_valid  out  1  chunk result writeback
wb_chunk  out  $clog2(VLEN/DATA_WIDTH)  writeback chunk index
wb_be  out  CHUNK_BYTES  writeback byte enables
wb_last  out  1  final writeback; micro-op complete
flush  in  1  kill current micro-op

Behaviour:
- Reset: state=IDLE. in_ready=1 the cycle after rst deasserts. All other outputs 0. Latency pipeline cleared.
- States: IDLE, ISSUE, DRAIN.
- IDLE: in_ready=1. Accept on in_valid&in_ready and compute nbytes = in_vl << in_sew.
  - If nbytes > VLEN/8: pulse in_err next cycle and stay in IDLE.
  - If nbytes == 0: pulse wb_valid=0, wb_last=1 next cycle and stay in IDLE.
  - Otherwise latch unit, nbytes, chunk=0 and go to ISSUE.
- ISSUE: iss_valid[unit]=1 with iss_chunk=chunk.
  - iss_be = all ones, except the final chunk, where iss_be = (1 << (nbytes mod CHUNK_BYTES)) - 1 when the remainder is nonzero.
  - iss_last=1 on chunk = ceil(nbytes/CHUNK_BYTES) - 1.
  - A chunk is issued only when iss_valid&iss_ready. While iss_ready=0, all iss_* outputs hold stable.
  - On an issued chunk: chunk++. After the last chunk is issued, go to DRAIN.
- Latency tracking: a shift register of depth ARITH_LAT carries {valid, chunk, be, last}.
  - An issue at cycle t produces wb_valid at t+LAT, where LAT=ARITH_LAT for arith and 1 otherwise.
  - Writeback cannot be back-pressured.
- DRAIN: wait for writeback with wb_last=1, then go to IDLE in the next cycle. in_ready=0 in ISSUE and DRAIN.
- First issue is at acceptance cycle +1. Back-to-back micro-ops: minimum one IDLE cycle between them.
- flush (highest priority after rst): in the flush cycle in_ready=0. Next cycle: state=IDLE, iss_valid=0, and the shift register is cleared, so pending writebacks are never produced.
  - flush while in IDLE with in_valid: the micro-op is not accepted.
- in_unit is sampled only at acceptance. Later changes to in_* are ignored.

Optional Feature:
Macro RISCV_V_EXE_ALU_CTRL_PERF_EN.
- When defined, adds outputs perf_busy_cycles[31:0] (cycles in ISSUE or DRAIN), perf_stall_cycles[31:0] (cycles with iss_valid!=0 and iss_ready=0) and perf_uops[31:0] (micro-ops completed via wb_last).
- All three counters saturate at 0xFFFFFFFF and reset to 0 on rst.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
1. Defaults. logic, vl=32, sew=0 (32B) -> iss_valid=4'b0001 on 4 consecutive cycles, chunks 0..3, be=0xFF, iss_last on chunk 3. Writebacks 1 cycle later each, wb_last with chunk 3. in_ready returns 1 the cycle after.
2. arith, vl=5, sew=1 (10B) -> 2 chunks with be 0xFF then 0x03. Each wb_valid occurs 2 cycles after its issue. wb_last on chunk 1.
3. vl=0 -> no iss_valid, wb_last pulse with wb_valid=0 one cycle after accept. vl=9, sew=2 (36B > 32B) -> in_err pulse, no issue, in_ready stays 1.
4. mask, vl=32, sew=0, iss_ready low for 3 cycles during chunk 1 -> chunk 1 and be held stable, no duplicate issue, 4 total writebacks in order.
5. arith, vl=32, sew=0, flush one cycle after chunk 2 issues -> no further issue. Writebacks for chunks 1 and 2 never appear. in_ready=1 two cycles after flush.
6. rst asserted in ISSUE -> all outputs 0 next cycle, in_ready=1 the cycle after release. With PERF_EN, counters read 0.
